// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with handshake fetch, flag branches, timed-out memory waits and a retire counter
module mc_control_unit #(
    parameter int IW          = 8,
    parameter int RAW         = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [IW-1:0]    instruction,
    output logic             instr_ready,
    input  logic             acc_zero,
    input  logic             acc_neg,
    input  logic             mem_ready,
    output logic [3:0]       alu_control,
    output logic [RAW-1:0]   reg_addr1,
    output logic [RAW-1:0]   reg_addr2,
    output logic             rf_wen,
    output logic             link_sel,
    output logic             flag_wen,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;
    state_t        state;
    logic [IW-1:0] ir;
    logic [7:0]    wcnt;
    logic [3:0]    op;
    logic          active, exec, mem, wb, timeout, br_take, alu_op;
    always_comb begin
        op          = ir[IW-1:IW-4];
        active      = state inside {DECODE, EXEC, MEM, WB};
        exec        = state == EXEC;
        mem         = state == MEM;
        wb          = state == WB;
        timeout     = wcnt == 8'(MEM_TIMEOUT - 1);
        alu_op      = op inside {[4'h0:4'h3], 4'h8, 4'h9, 4'hC, 4'hD};
        br_take     = (op == 4'hA && !acc_zero) || (op == 4'hB && acc_neg) || op == 4'hE || op == 4'hF;
        instr_ready = state == FETCH;
        reg_addr1   = active ? ir[2*RAW-1:RAW] : '0;
        reg_addr2   = active ? ir[RAW-1:0] : '0;
        alu_control = !active ? 4'h0 : (op == 4'h8 || op == 4'h9) ? 4'h0 : op == 4'hA ? 4'h1 : op;
        pc_load     = exec && br_take;
        // completion beats timeout when mem_ready arrives on the last allowed cycle
        pc_inc      = (exec && ((op inside {4'hA, 4'hB} && !br_take) || op inside {4'h6, 4'h7}))
                    || (mem && (mem_ready ? op == 4'h5 : timeout)) || wb;
        rf_wen      = wb || (exec && op == 4'hF);
        link_sel    = exec && op == 4'hF;
        flag_wen    = wb && op inside {[4'h0:4'h3], 4'hC, 4'hD};
        mem_ren     = mem && op == 4'h4;
        mem_wen     = mem && op == 4'h5;
        illegal     = exec && op inside {4'h6, 4'h7};
        mem_err     = mem && !mem_ready && timeout;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ir          <= '0;
            wcnt        <= '0;
            instr_count <= '0;
        end else begin
            instr_count <= instr_count + CNT_W'(pc_inc | pc_load);
            case (state)
                IDLE:    state <= FETCH;
                FETCH:   if (instr_valid) begin
                    ir    <= instruction;
                    state <= DECODE;
                end
                DECODE:  state <= EXEC;
                EXEC: begin
                    wcnt  <= '0;
                    state <= op inside {4'h4, 4'h5} ? MEM : alu_op ? WB : FETCH;
                end
                MEM: begin
                    wcnt  <= wcnt + 8'd1;
                    state <= mem_ready ? (op == 4'h4 ? WB : FETCH) : timeout ? FETCH : MEM;
                end
                WB:      state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized scoreboard bench; per-instruction expectations come from an opcode-level behavioural model
module tb_mc_control_unit;
    localparam int IW = 8, RAW = 2, T = 15, CW = 4;
    logic clk = 0, reset = 0, instr_valid = 0, acc_zero = 0, acc_neg = 0, mem_ready = 0;
    logic [IW-1:0] instruction = '0;
    logic instr_ready, rf_wen, link_sel, flag_wen, mem_ren, mem_wen, pc_inc, pc_load, illegal, mem_err;
    logic [3:0] alu_control;
    logic [RAW-1:0] reg_addr1, reg_addr2;
    logic [CW-1:0] instr_count;

    mc_control_unit #(.IW(IW), .RAW(RAW), .MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
        .instr_ready(instr_ready), .acc_zero(acc_zero), .acc_neg(acc_neg), .mem_ready(mem_ready),
        .alu_control(alu_control), .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
        .rf_wen(rf_wen), .link_sel(link_sel), .flag_wen(flag_wen), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .pc_inc(pc_inc), .pc_load(pc_load), .illegal(illegal),
        .mem_err(mem_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat; int alu; int a1; int a2; int inc; int load; int rf; int jal;
        int flag; int ill; int err; int ren; int wen; int cnt;
    } exp_t;

    exp_t q[$];
    int tests = 0, fails = 0, retired = 0;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bail(string name);
        fails++;
        $display("FAIL timeout %s", name);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "bench stopped");
    endtask

    // Opcode-level behaviour: w = MEM cycles spent without mem_ready before it rises
    function automatic exp_t model(logic [7:0] ins, bit z, bit n, int w);
        exp_t e = '{default: 0};
        int op = int'(ins[7:4]);
        e.alu = (op == 8 || op == 9) ? 0 : op == 10 ? 1 : op;
        e.a1 = int'(ins[3:2]);
        e.a2 = int'(ins[1:0]);
        case (op)
            4: if (w < T) begin e.lat = 4 + w; e.ren = w + 1; e.rf = 1; end
               else begin e.lat = 2 + T; e.ren = T; e.err = 1; end
            5: if (w < T) begin e.lat = 3 + w; e.wen = w + 1; end
               else begin e.lat = 2 + T; e.wen = T; e.err = 1; end
            6, 7: begin e.lat = 2; e.ill = 1; end
            10: begin e.lat = 2; e.load = !z; end
            11: begin e.lat = 2; e.load = n; end
            14: begin e.lat = 2; e.load = 1; end
            15: begin e.lat = 2; e.load = 1; e.rf = 1; e.jal = 1; end
            default: begin e.lat = 3; e.rf = 1; e.flag = (op <= 3 || op == 12 || op == 13); end
        endcase
        e.inc = e.load ? 0 : 1;
        return e;
    endfunction

    task automatic issue(logic [7:0] ins, bit z, bit n, int w, int gap);
        exp_t e;
        int k;
        instr_valid = 0;
        mem_ready = 0;
        repeat (gap) begin @(posedge clk); #2; instruction = IW'($urandom); end
        instruction = ins;
        acc_zero = z;
        acc_neg = n;
        instr_valid = 1;
        k = 0;
        while (!instr_ready) begin
            @(posedge clk); #2;
            if (++k > 50) bail("handshake");
        end
        e = model(ins, z, n, w);
        retired++;
        e.cnt = retired % (1 << CW);
        q.push_back(e);
        @(posedge clk); #2;
        instr_valid = 0;
        instruction = IW'($urandom);
        k = 1;
        while (!instr_ready) begin
            mem_ready = (k == 3 + w);
            @(posedge clk); #2;
            instruction = IW'($urandom);
            if (++k > 400) bail("retire");
        end
        mem_ready = 0;
    endtask

    // Monitor: tallies strobes of each in-flight instruction and scores it at retire
    initial begin
        exp_t e;
        bit busy = 0, chk_cnt = 0;
        int exp_cnt = 0, lat = 0, t_inc = 0, t_load = 0, t_rf = 0, t_jal = 0, t_flag = 0;
        int t_ill = 0, t_err = 0, t_ren = 0, t_wen = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy = 0;
                chk_cnt = 0;
                q.delete();
            end else begin
                if (chk_cnt) begin
                    check("instr_count", int'(instr_count), exp_cnt);
                    chk_cnt = 0;
                end
                if (busy) begin
                    lat++;
                    t_inc += int'(pc_inc); t_load += int'(pc_load); t_rf += int'(rf_wen);
                    t_jal += int'(pc_load & rf_wen & link_sel); t_flag += int'(flag_wen);
                    t_ill += int'(illegal & pc_inc); t_err += int'(mem_err & pc_inc);
                    t_ren += int'(mem_ren); t_wen += int'(mem_wen);
                    if (pc_inc | pc_load) begin
                        if (q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL retire: got retire expected none pending");
                        end else begin
                            e = q.pop_front();
                            check("latency", lat, e.lat);
                            check("alu_control", int'(alu_control), e.alu);
                            check("reg_addr1", int'(reg_addr1), e.a1);
                            check("reg_addr2", int'(reg_addr2), e.a2);
                            check("pc_inc", t_inc, e.inc);
                            check("pc_load", t_load, e.load);
                            check("rf_wen", t_rf, e.rf);
                            check("jal_link", t_jal, e.jal);
                            check("flag_wen", t_flag, e.flag);
                            check("illegal", t_ill, e.ill);
                            check("mem_err", t_err, e.err);
                            check("mem_ren_cycles", t_ren, e.ren);
                            check("mem_wen_cycles", t_wen, e.wen);
                            exp_cnt = e.cnt;
                            chk_cnt = 1;
                        end
                        busy = 0;
                    end
                end else if (instr_valid && instr_ready) begin
                    check("fetch_quiet", int'({rf_wen, link_sel, flag_wen, mem_ren, mem_wen,
                          pc_inc, pc_load, illegal, mem_err, alu_control}), 0);
                    busy = 1;
                    lat = 0; t_inc = 0; t_load = 0; t_rf = 0; t_jal = 0; t_flag = 0;
                    t_ill = 0; t_err = 0; t_ren = 0; t_wen = 0;
                end
            end
        end
    end

    initial begin
        #900000;
        bail("watchdog");
    end

    initial begin
        logic [3:0] op;
        int k;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", int'({instr_ready, alu_control, reg_addr1, reg_addr2, rf_wen, link_sel,
              flag_wen, mem_ren, mem_wen, pc_inc, pc_load, illegal, mem_err, instr_count}), 0);
        reset = 1;
        #1 check("idle_not_ready", int'(instr_ready), 0);
        repeat (2) @(posedge clk);
        #2;
        check("fetch_ready", int'(instr_ready), 1);
        check("count_after_reset", int'(instr_count), 0);

        issue(8'h06, 0, 0, 0, 0);
        issue(8'hA4, 0, 0, 0, 1);
        issue(8'hA4, 1, 0, 0, 0);
        issue(8'hB0, 0, 1, 0, 0);
        issue(8'h41, 0, 0, 3, 0);
        issue(8'h52, 0, 0, 1000, 0);
        issue(8'h4B, 0, 0, T - 1, 0);
        issue(8'h6F, 0, 0, 0, 0);
        issue(8'hF0, 0, 0, 0, 2);
        repeat (150) begin
            op = 4'($urandom_range(0, 15));
            issue({op, 4'($urandom)}, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0 ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 4),
                  $urandom_range(0, 2));
        end
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);

        // Reset pulled low while a load sits in MEM
        instruction = 8'h41;
        instr_valid = 1;
        @(posedge clk); #2;
        instr_valid = 0;
        k = 0;
        while (!mem_ren && k < 20) begin @(posedge clk); #2; k++; end
        check("ld_mem_ren", int'(mem_ren), 1);
        @(posedge clk); #3;
        reset = 0;
        retired = 0;
        #1;
        check("async_mem_ren_drop", int'(mem_ren), 0);
        check("async_outputs_zero", int'({instr_ready, alu_control, reg_addr1, reg_addr2, rf_wen,
              link_sel, flag_wen, mem_wen, pc_inc, pc_load, instr_count}), 0);
        @(posedge clk); #2;
        reset = 1;
        repeat (17) begin
            do op = 4'($urandom_range(0, 15)); while (op == 4'h4 || op == 4'h5);
            issue({op, 4'($urandom)}, 1'($urandom), 1'($urandom), 0, 0);
        end
        repeat (2) @(posedge clk);
        #2;
        check("count_wrap", int'(instr_count), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
